ps2_autotype: RTL



---
 rtl/ps2_autotype.sv | 119 +++++++++++
 1 files changed

// File: rtl/ps2_autotype.sv
// ps2_autotype: replays queued characters as timed PS/2 press/release events merged with the live keyboard stream
// Ports: clk, reset_n (async, active-low); wr/wr_data {shift,ext,code} push a FIFO entry;
// abort flushes the FIFO and releases held injected keys; ps2_key_in/key_extended_in carry live
// toggle-flag events; ps2_key_out/key_extended_out carry the merged stream; full, busy report status.
// Optional: define AUTOTYPE_ABORT_ON_KEY_EN to make any forwarded live press abort the injection.
module ps2_autotype #(
  parameter int DEPTH    = 16,
  parameter int HOLD_CYC = 2500000,
  parameter int GAP_CYC  = 2500000,
  parameter int CNT_W    = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr,
  input  logic [9:0]  wr_data,
  input  logic        abort,
  input  logic [10:0] ps2_key_in,
  input  logic        key_extended_in,
  output logic [10:0] ps2_key_out,
  output logic        key_extended_out,
  output logic        full,
  output logic        busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] HOLD_L = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_CYC - 1);
  typedef enum logic [2:0] {IDLE, S_DN, K_DN, K_UP, S_UP} st_t;
  st_t state, w_st, nxt;
  logic [9:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic [9:0] cur, head, ev;
  logic [8:0] src;
  logic [CNT_W-1:0] tmr, ld;
  logic pend, abt, kd, sd, prev_tog, live_edge, abort_eff, ab_mode, empty, push, pop, want, go;
`ifdef AUTOTYPE_ABORT_ON_KEY_EN
  logic abk_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) abk_q <= 1'b0;
    else abk_q <= live_edge & ps2_key_in[9];
  assign abort_eff = abort | abk_q;
`else
  assign abort_eff = abort;
`endif
  // w_st is the state whose event wants out this cycle; during abort only releases of keys
  // actually pressed (kd/sd) are generated, back to back with no gap.
  always_comb begin
    head = mem[rp];
    empty = cnt == '0;
    full = cnt == (AW+1)'(DEPTH);
    busy = !empty || state != IDLE;
    live_edge = ps2_key_in[10] ^ prev_tog;
    ab_mode = abort_eff | abt;
    nxt = state == S_DN ? K_DN : state == K_DN ? K_UP : (state == K_UP && cur[9]) ? S_UP : IDLE;
    w_st = ab_mode ? (kd ? K_UP : S_UP) : pend ? state : state == IDLE ? (head[9] ? S_DN : K_DN) : nxt;
    want = ab_mode ? (kd | sd) : pend | (state == IDLE ? !empty : (tmr == '0 && nxt != IDLE));
    go = want & !live_edge;
    pop = !ab_mode & !pend & state == IDLE & !empty;
    push = wr & !full & !abort_eff;
    src = pop ? head[8:0] : cur[8:0];
    ev = {w_st == S_DN || w_st == K_DN, (w_st == K_DN || w_st == K_UP) & src[8],
          (w_st == S_DN || w_st == S_UP) ? 8'h12 : src[7:0]};
    ld = (w_st == S_DN || w_st == K_DN) ? HOLD_L : GAP_L;
  end
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cur <= '0;
      tmr <= '0;
      pend <= 1'b0;
      abt <= 1'b0;
      kd <= 1'b0;
      sd <= 1'b0;
      prev_tog <= 1'b0;
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      ps2_key_out <= '0;
      key_extended_out <= 1'b0;
    end else begin
      prev_tog <= ps2_key_in[10];
      if (live_edge) begin
        ps2_key_out <= {~ps2_key_out[10], ps2_key_in[9:0]};
        key_extended_out <= key_extended_in;
      end else if (go) begin
        ps2_key_out <= {~ps2_key_out[10], ev};
        key_extended_out <= ev[8];
      end
      if (abort_eff) begin
        rp <= wp;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop) rp <= rp + 1'b1;
        cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
      if (go) begin
        if (w_st == S_DN) sd <= 1'b1;
        if (w_st == S_UP) sd <= 1'b0;
        if (w_st == K_DN) kd <= 1'b1;
        if (w_st == K_UP) kd <= 1'b0;
      end
      if (pop) cur <= head;
      abt <= ab_mode & want;
      pend <= !ab_mode & want & !go;
      // the timer is loaded only when the event really leaves, so a live collision delays it
      if (ab_mode) begin
        tmr <= '0;
        state <= want ? (go ? w_st : state) : IDLE;
      end else if (want) begin
        state <= w_st;
        if (go) tmr <= ld;
      end else if (tmr != '0) tmr <= tmr - 1'b1;
      else state <= IDLE;
    end
  end
endmodule
